// File: rtl/psr_flag_sequencer_if.sv
// Request/acknowledge and status bundle between the P-register sequencer and its requesters.
interface psr_flag_sequencer_if;
  logic       irq_req;
  logic       irq_is_brk;
  logic       irq_ack;
  logic       plp_req;
  logic [7:0] plp_data;
  logic       plp_ack;
  logic       alu_req;
  logic [3:0] alu_mask;
  logic [3:0] alu_nvzc;
  logic       alu_ack;
  logic       flg_req;
  logic [2:0] flg_op;
  logic       flg_ack;
  logic       sob_n;
  logic [7:0] p_out;
  logic [7:0] push_data;
  logic       c_carry;
  logic       d_decimal;

  modport master (
    output irq_req, irq_is_brk, plp_req, plp_data, alu_req, alu_mask, alu_nvzc,
           flg_req, flg_op, sob_n,
    input  irq_ack, plp_ack, alu_ack, flg_ack, p_out, push_data, c_carry, d_decimal
  );

  modport slave (
    input  irq_req, irq_is_brk, plp_req, plp_data, alu_req, alu_mask, alu_nvzc,
           flg_req, flg_op, sob_n,
    output irq_ack, plp_ack, alu_ack, flg_ack, p_out, push_data, c_carry, d_decimal
  );
endinterface

// File: rtl/psr_flag_sequencer.sv
// Processor status register owner: arbitrates irq > plp > alu > flg writes and folds in the SOB pin.
// Define PSR_SOB_SYNC_EN to pass sob_n through a 2-flop synchronizer before edge detection.
module psr_flag_sequencer #(
  parameter logic [7:0] RESET_P        = 8'h34,
  parameter bit         CLEAR_D_ON_INT = 1'b1
) (
  input  logic               fclk,
  input  logic               reset,
  psr_flag_sequencer_if.slave bus
);

  logic [7:0] r_p;
  logic [7:0] r_pushData;
  logic       r_irqAck;
  logic       r_plpAck;
  logic       r_aluAck;
  logic       r_flgAck;
  logic       r_sobPending;

  logic       w_irqGrant;
  logic       w_plpGrant;
  logic       w_aluGrant;
  logic       w_flgGrant;
  logic       w_sobFall;
  logic [7:0] w_pNext;
  logic [7:0] w_pushNext;

  // A requester whose ack is showing this cycle is not eligible, which lets the next one in line win
  always_comb begin
    w_irqGrant = bus.irq_req & ~r_irqAck;
    w_plpGrant = ~w_irqGrant & bus.plp_req & ~r_plpAck;
    w_aluGrant = ~w_irqGrant & ~w_plpGrant & bus.alu_req & ~r_aluAck;
    w_flgGrant = ~w_irqGrant & ~w_plpGrant & ~w_aluGrant & bus.flg_req & ~r_flgAck;
  end

  always_comb begin
    w_pNext    = r_p;
    w_pushNext = r_pushData;
    if (w_irqGrant) begin
      w_pushNext = {r_p[7:6], 1'b1, bus.irq_is_brk, r_p[3:0]};
      w_pNext[2] = 1'b1;
      if (CLEAR_D_ON_INT) w_pNext[3] = 1'b0;
    end else if (w_plpGrant) begin
      w_pNext = bus.plp_data;
    end else if (w_aluGrant) begin
      if (bus.alu_mask[3]) w_pNext[7] = bus.alu_nvzc[3];
      if (bus.alu_mask[2]) w_pNext[6] = bus.alu_nvzc[2];
      if (bus.alu_mask[1]) w_pNext[1] = bus.alu_nvzc[1];
      if (bus.alu_mask[0]) w_pNext[0] = bus.alu_nvzc[0];
    end else if (w_flgGrant) begin
      case (bus.flg_op)
        3'd0:    w_pNext[0] = 1'b0;
        3'd1:    w_pNext[0] = 1'b1;
        3'd2:    w_pNext[2] = 1'b0;
        3'd3:    w_pNext[2] = 1'b1;
        3'd4:    w_pNext[6] = 1'b0;
        3'd5:    w_pNext[3] = 1'b0;
        3'd6:    w_pNext[3] = 1'b1;
        default: w_pNext    = r_p;
      endcase
    end
    // SOB wins over whatever V the granted source wanted this edge
    if (r_sobPending) w_pNext[6] = 1'b1;
    w_pNext[5:4] = 2'b11;
  end

`ifdef PSR_SOB_SYNC_EN
  logic r_sobSync1;
  logic r_sobSync2;

  always_ff @(posedge fclk) begin
    if (reset) begin
      r_sobSync1 <= 1'b1;
      r_sobSync2 <= 1'b1;
    end else begin
      r_sobSync1 <= bus.sob_n;
      r_sobSync2 <= r_sobSync1;
    end
  end

  assign w_sobFall = r_sobSync2 & ~r_sobSync1;
`else
  logic r_sobPrev;

  always_ff @(posedge fclk) begin
    if (reset) r_sobPrev <= 1'b1;
    else       r_sobPrev <= bus.sob_n;
  end

  assign w_sobFall = r_sobPrev & ~bus.sob_n;
`endif

  always_ff @(posedge fclk) begin
    if (reset) begin
      r_p          <= RESET_P | 8'h30;
      r_pushData   <= 8'h30;
      r_irqAck     <= 1'b0;
      r_plpAck     <= 1'b0;
      r_aluAck     <= 1'b0;
      r_flgAck     <= 1'b0;
      r_sobPending <= 1'b0;
    end else begin
      r_p          <= w_pNext;
      r_pushData   <= w_pushNext;
      r_irqAck     <= w_irqGrant;
      r_plpAck     <= w_plpGrant;
      r_aluAck     <= w_aluGrant;
      r_flgAck     <= w_flgGrant;
      r_sobPending <= w_sobFall & ~r_sobPending;
    end
  end

  assign bus.irq_ack   = r_irqAck;
  assign bus.plp_ack   = r_plpAck;
  assign bus.alu_ack   = r_aluAck;
  assign bus.flg_ack   = r_flgAck;
  assign bus.p_out     = r_p;
  assign bus.push_data = r_pushData;
  assign bus.c_carry   = r_p[0];
  assign bus.d_decimal = r_p[3];

endmodule

// File: tb/tb_psr_flag_sequencer.sv
// Directed bench for psr_flag_sequencer: reset, arbitration, irq push image, flag ops, SOB override.
module tb_psr_flag_sequencer;

  logic fclk;
  logic reset;
  int   compared;
  int   mismatched;
  logic [3:0] acks;

  psr_flag_sequencer_if bus ();

  psr_flag_sequencer dut (
    .fclk  (fclk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef PSR_SOB_SYNC_EN
  localparam int SOB_LAT = 3;
`else
  localparam int SOB_LAT = 2;
`endif

  assign acks = {bus.irq_ack, bus.plp_ack, bus.alu_ack, bus.flg_ack};

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic applyStimulus(input logic irq, input logic brk, input logic plp,
                               input logic [7:0] plpData, input logic alu,
                               input logic [3:0] mask, input logic [3:0] nvzc,
                               input logic flg, input logic [2:0] op, input logic sobN);
    bus.irq_req    = irq;
    bus.irq_is_brk = brk;
    bus.plp_req    = plp;
    bus.plp_data   = plpData;
    bus.alu_req    = alu;
    bus.alu_mask   = mask;
    bus.alu_nvzc   = nvzc;
    bus.flg_req    = flg;
    bus.flg_op     = op;
    bus.sob_n      = sobN;
  endtask

  task automatic idle(input logic sobN);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, sobN);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One flag opcode: grant, check P and ack, then release and let the ack drop
  task automatic flagOp(input logic [2:0] op, input logic [7:0] expP);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, op, 1'b1);
    tick();
    checkOutput($sformatf("flg_op%0d_p", op), bus.p_out, expP);
    checkOutput($sformatf("flg_op%0d_ack", op), {4'h0, acks}, 8'h01);
    idle(1'b1);
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    idle(1'b1);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_p", bus.p_out, 8'h34);
    checkOutput("reset_push", bus.push_data, 8'h30);
    checkOutput("reset_acks", {4'h0, acks}, 8'h00);

    // Load P=00 (bits 5/4 forced), then reset restores RESET_P
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 1'b1);
    tick();
    checkOutput("plp00_p", bus.p_out, 8'h30);
    checkOutput("plp00_ack", {4'h0, acks}, 8'h04);
    idle(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst2_p", bus.p_out, 8'h34);
    checkOutput("rst2_push", bus.push_data, 8'h30);
    checkOutput("rst2_acks", {4'h0, acks}, 8'h00);

    // ALU masked update keeps V
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'b1011, 4'b1001, 1'b0, 3'd7, 1'b1);
    tick();
    checkOutput("alu_p", bus.p_out, 8'hB5);
    checkOutput("alu_ack", {4'h0, acks}, 8'h02);
    idle(1'b1);
    tick();
    checkOutput("alu_ack_drop", {4'h0, acks}, 8'h00);

    // Three simultaneous requesters served irq, plp, alu on consecutive cycles
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h3D, 1'b1, 4'b0001, 4'b0000, 1'b0, 3'd7, 1'b1);
    tick();
    checkOutput("arb1_acks", {4'h0, acks}, 8'h08);
    checkOutput("arb1_p", bus.p_out, 8'hB5);
    checkOutput("arb1_push", bus.push_data, 8'hA5);
    bus.irq_req = 1'b0;
    tick();
    checkOutput("arb2_acks", {4'h0, acks}, 8'h04);
    checkOutput("arb2_p", bus.p_out, 8'h3D);
    bus.plp_req = 1'b0;
    tick();
    checkOutput("arb3_acks", {4'h0, acks}, 8'h02);
    checkOutput("arb3_p", bus.p_out, 8'h3C);
    idle(1'b1);
    tick();
    checkOutput("arb4_acks", {4'h0, acks}, 8'h00);

    // BRK entry from P=3D
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3D, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 1'b1);
    tick();
    idle(1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 1'b1);
    tick();
    checkOutput("brk_push", bus.push_data, 8'h3D);
    checkOutput("brk_p", bus.p_out, 8'h35);
    idle(1'b1);
    tick();

    // IRQ entry from P=3D
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3D, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 1'b1);
    tick();
    idle(1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 1'b1);
    tick();
    checkOutput("irq_push", bus.push_data, 8'h2D);
    checkOutput("irq_p", bus.p_out, 8'h35);
    idle(1'b1);
    tick();

    // SOB lands on the same edge as a CLV grant; V must end up set
    idle(1'b0);
    for (int i = 0; i < SOB_LAT - 1; i++) tick();
    checkOutput("sob_wait_p", bus.p_out, 8'h35);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 3'd4, 1'b0);
    tick();
    checkOutput("sob_clv_p", bus.p_out, 8'h75);
    checkOutput("sob_clv_ack", {4'h0, acks}, 8'h01);
    idle(1'b1);
    tick();
    checkOutput("sob_hold_p", bus.p_out, 8'h75);
    flagOp(3'd4, 8'h35);

    // SOB also overrides a PLP load of V=0
    idle(1'b0);
    for (int i = 0; i < SOB_LAT - 1; i++) tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 1'b0);
    tick();
    checkOutput("sob_plp_p", bus.p_out, 8'h70);
    idle(1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h35, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 1'b1);
    tick();
    idle(1'b1);
    tick();

    flagOp(3'd0, 8'h34);
    flagOp(3'd1, 8'h35);
    flagOp(3'd3, 8'h35);
    flagOp(3'd2, 8'h31);
    flagOp(3'd6, 8'h39);
    checkOutput("sed_c", {7'h0, bus.c_carry}, 8'h01);
    checkOutput("sed_d", {7'h0, bus.d_decimal}, 8'h01);
    flagOp(3'd5, 8'h31);
    checkOutput("cld_d", {7'h0, bus.d_decimal}, 8'h00);
    flagOp(3'd7, 8'h31);

    // Reset during the ALU ack cycle discards the handshake
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'hF, 4'hF, 1'b0, 3'd7, 1'b1);
    tick();
    checkOutput("alu_all_p", bus.p_out, 8'hF3);
    checkOutput("alu_all_ack", {4'h0, acks}, 8'h02);
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_acks", {4'h0, acks}, 8'h00);
    checkOutput("rst_mid_p", bus.p_out, 8'h34);
    reset = 1'b0;
    idle(1'b1);
    tick();
    checkOutput("rst_after_acks", {4'h0, acks}, 8'h00);
    checkOutput("rst_after_p", bus.p_out, 8'h34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
